// File: rtl/hdmi_stream_aligner_if.sv
// Pixel stream handshake (data/valid/ready plus sof/eol) into hdmi_stream_aligner.
// Member names are given from the aligner's point of view.
interface hdmi_stream_aligner_if #(
  parameter int PIX_W = 24
);
  logic [PIX_W-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic             i_sof;
  logic             i_eol;

  modport master (output i_data, i_valid, i_sof, i_eol, input o_ready);
  modport slave  (input i_data, i_valid, i_sof, i_eol, output o_ready);
endinterface

// File: rtl/hdmi_stream_aligner.sv
// Buffers a framed pixel stream and releases it to the HDMI encoder locked to its frame start.
// Optional macro HDMI_ALIGN_BARS_EN: colour bars instead of FILL_COLOR while unlocked.
module hdmi_stream_aligner #(
  parameter int               PIX_W      = 24,
  parameter int               DEPTH      = 1024,
  parameter int               ACTIVE_W   = 1280,
  parameter logic [PIX_W-1:0] FILL_COLOR = '0
) (
  input  logic                 i_clk_pixel,
  input  logic                 i_rstn,
  hdmi_stream_aligner_if.slave s_if,
  input  logic                 i_active,
  input  logic                 i_frame_start,
  output logic [PIX_W-1:0]     o_rgb,
  output logic                 o_locked,
  output logic                 o_underflow,
  output logic                 o_sync_err,
  output logic [15:0]          o_err_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(ACTIVE_W);
  localparam int CH_W  = PIX_W / 3;
  localparam int ENT_W = PIX_W + 2;
  localparam logic [CW-1:0] LAST_COL = CW'(ACTIVE_W - 1);

  typedef enum logic [1:0] {
    ST_RESYNC,
    ST_WAIT_FRAME,
    ST_STREAM
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [ENT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, empty, push, pop;
  logic [ENT_W-1:0] head;
  logic             head_sof, head_eol;
  logic [PIX_W-1:0] head_data;

  assign full        = (count_q == (AW+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign s_if.o_ready = !full;
  assign push        = s_if.i_valid && !full;

  assign head      = mem[rd_ptr_q];
  assign head_sof  = head[ENT_W-1];
  assign head_eol  = head[ENT_W-2];
  assign head_data = head[PIX_W-1:0];

  always_ff @(posedge i_clk_pixel) begin
    if (push) begin
      mem[wr_ptr_q] <= {s_if.i_sof, s_if.i_eol, s_if.i_data};
    end
  end

  // Resetting the pointers is enough to discard everything buffered.
  always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ------------------------------------------------ pixel while unlocked
  logic [PIX_W-1:0] idle_pix;

`ifdef HDMI_ALIGN_BARS_EN
  localparam int BW = $clog2(ACTIVE_W + 1);
  localparam int B1 = ACTIVE_W / 3;
  localparam int B2 = (2 * ACTIVE_W) / 3;

  logic [BW-1:0] bar_cnt_q;
  logic [1:0]    bar_sel;

  always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
    if (!i_rstn) begin
      bar_cnt_q <= '0;
    end else if (!i_active) begin
      bar_cnt_q <= '0;
    end else if (bar_cnt_q != '1) begin
      bar_cnt_q <= bar_cnt_q + BW'(1);
    end
  end

  always_comb begin
    bar_sel = 2'd2;
    if (bar_cnt_q < BW'(B1)) begin
      bar_sel = 2'd0;
    end else if (bar_cnt_q < BW'(B2)) begin
      bar_sel = 2'd1;
    end
  end

  // Channel 0 (LSBs) is blue, channel 2 (MSBs) is red.
  for (genvar gi = 0; gi < 3; gi++) begin : g_bar_ch
    assign idle_pix[gi*CH_W +: CH_W] = (bar_sel == 2'(gi)) ? {CH_W{1'b1}} : {CH_W{1'b0}};
  end
`else
  assign idle_pix = FILL_COLOR;
`endif

  // ----------------------------------------------------------------- FSM
  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [PIX_W-1:0] rgb_q, rgb_d;
  logic             locked_q, uf_q, uf_d, se_q, se_d;
  logic [15:0]      err_cnt_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    rgb_d   = FILL_COLOR;
    uf_d    = 1'b0;
    se_d    = 1'b0;
    pop     = 1'b0;
    if (i_active && state_q != ST_STREAM) begin
      rgb_d = idle_pix;
    end
    case (state_q)
      ST_RESYNC: begin
        col_d = '0;
        if (!empty) begin
          if (head_sof) state_d = ST_WAIT_FRAME;
          else          pop     = 1'b1;
        end
      end
      ST_WAIT_FRAME: begin
        if (i_active && i_frame_start) begin
          if (!empty && head_sof) begin
            pop     = 1'b1;
            rgb_d   = head_data;
            col_d   = CW'(1);
            state_d = ST_STREAM;
          end else begin
            uf_d    = 1'b1;
            col_d   = '0;
            state_d = ST_RESYNC;
          end
        end
      end
      ST_STREAM: begin
        if (i_active) begin
          if (empty) begin
            uf_d    = 1'b1;
            col_d   = '0;
            state_d = ST_RESYNC;
          end else if (head_sof && !i_frame_start) begin
            // Early sof stays in the FIFO so resync can lock onto it.
            se_d    = 1'b1;
            col_d   = '0;
            state_d = ST_RESYNC;
          end else begin
            pop   = 1'b1;
            rgb_d = head_data;
            if ((i_frame_start && !head_sof) || (head_eol != (col_q == LAST_COL))) begin
              se_d    = 1'b1;
              col_d   = '0;
              state_d = ST_RESYNC;
            end else if (head_eol) begin
              col_d = '0;
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
      default: begin
        col_d   = '0;
        state_d = ST_RESYNC;
      end
    endcase
  end

  always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= ST_RESYNC;
      col_q     <= '0;
      rgb_q     <= FILL_COLOR;
      locked_q  <= 1'b0;
      uf_q      <= 1'b0;
      se_q      <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      rgb_q    <= rgb_d;
      locked_q <= (state_d == ST_STREAM);
      uf_q     <= uf_d;
      se_q     <= se_d;
      if ((uf_d || se_d) && err_cnt_q != 16'hFFFF) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign o_rgb       = rgb_q;
  assign o_locked    = locked_q;
  assign o_underflow = uf_q;
  assign o_sync_err  = se_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_hdmi_stream_aligner.sv
// Scoreboard bench for hdmi_stream_aligner: a queue-based line/frame model predicts
// every cycle's outputs, a separate monitor compares them one cycle later.
module tb_hdmi_stream_aligner;

  localparam int          PIX_W    = 24;
  localparam int          DEPTH    = 16;
  localparam int          ACTIVE_W = 8;
  localparam logic [23:0] FILL     = 24'h101010;

  localparam int HUNT = 0, ARMED = 1, LOCK = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        act, fs;
  logic [23:0] rgb;
  logic        locked, uf, se;
  logic [15:0] errc;

  always #5 clk = ~clk;

  hdmi_stream_aligner_if #(.PIX_W(PIX_W)) s_if ();

  hdmi_stream_aligner #(
    .PIX_W(PIX_W), .DEPTH(DEPTH), .ACTIVE_W(ACTIVE_W), .FILL_COLOR(FILL)
  ) dut (
    .i_clk_pixel  (clk),
    .i_rstn       (rstn),
    .s_if         (s_if),
    .i_active     (act),
    .i_frame_start(fs),
    .o_rgb        (rgb),
    .o_locked     (locked),
    .o_underflow  (uf),
    .o_sync_err   (se),
    .o_err_cnt    (errc)
  );

  typedef struct {
    logic [23:0] data;
    bit          sof;
    bit          eol;
  } pix_t;

  typedef struct {
    logic [23:0] rgb;
    bit          locked;
    bit          uf;
    bit          se;
    bit          ready;
    int          err;
    bit          is_pix;
  } exp_t;

  pix_t src[$];     // pixels the source still has to deliver
  pix_t mq[$];      // model of what is buffered in the aligner
  exp_t exp_q[$];   // scoreboard

  int checks   = 0;
  int failures = 0;
  int vprob    = 100;
  int m_mode, m_col, m_err, m_run;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic add_pix(input logic [23:0] d, input bit s, input bit e);
    pix_t p;
    p.data = d; p.sof = s; p.eol = e;
    src.push_back(p);
  endtask

  // One clock cycle: drive inputs, advance the model, queue what must appear after the edge.
  task automatic tick(input bit a, input bit f, input bit rst_on);
    exp_t e;
    bit   offer, push, pop, line_end;
    @(negedge clk);
    act = a;
    fs  = f;
    e = '{rgb: FILL, locked: 1'b0, uf: 1'b0, se: 1'b0, ready: 1'b1, err: 0, is_pix: 1'b0};
    if (rst_on) begin
      rstn = 1'b0;
      s_if.i_valid = 1'b0;
      mq.delete();
      m_mode = HUNT; m_col = 0; m_err = 0; m_run = 0;
      exp_q.push_back(e);
      return;
    end
    rstn  = 1'b1;
    offer = (src.size() > 0) && ($urandom_range(99) < vprob);
    s_if.i_valid = offer;
    if (offer) begin
      s_if.i_data = src[0].data; s_if.i_sof = src[0].sof; s_if.i_eol = src[0].eol;
    end else begin
      s_if.i_data = 24'($urandom); s_if.i_sof = 1'($urandom); s_if.i_eol = 1'($urandom);
    end
    push = offer && (mq.size() < DEPTH);
    pop  = 1'b0;

    if (a && m_mode != LOCK) begin
`ifdef HDMI_ALIGN_BARS_EN
      if (m_run < ACTIVE_W / 3)          e.rgb = 24'h0000FF;
      else if (m_run < 2 * ACTIVE_W / 3) e.rgb = 24'h00FF00;
      else                               e.rgb = 24'hFF0000;
`else
      e.rgb = FILL;
`endif
    end
    m_run = a ? m_run + 1 : 0;

    if (m_mode == HUNT) begin
      if (mq.size() > 0) begin
        if (mq[0].sof) m_mode = ARMED;
        else           pop = 1'b1;
      end
    end else if (m_mode == ARMED) begin
      if (a && f) begin
        if (mq.size() > 0 && mq[0].sof) begin
          pop = 1'b1; e.rgb = mq[0].data; e.is_pix = 1'b1; m_col = 1; m_mode = LOCK;
        end else begin
          e.uf = 1'b1; m_mode = HUNT; m_col = 0;
        end
      end
    end else if (a) begin
      if (mq.size() == 0) begin
        e.uf = 1'b1; m_mode = HUNT; m_col = 0;
      end else if (mq[0].sof && !f) begin
        e.se = 1'b1; m_mode = HUNT; m_col = 0;
      end else begin
        pop = 1'b1; e.rgb = mq[0].data; e.is_pix = 1'b1;
        // m_col pixels of this line already sent; this one must carry eol iff it completes the line
        line_end = (m_col + 1 == ACTIVE_W);
        if ((f && !mq[0].sof) || (mq[0].eol != line_end)) begin
          e.se = 1'b1; m_mode = HUNT; m_col = 0;
        end else begin
          m_col = line_end ? 0 : m_col + 1;
        end
      end
    end

    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(src[0]);
      void'(src.pop_front());
    end
    if ((e.uf || e.se) && m_err < 65535) m_err++;
    e.locked = (m_mode == LOCK);
    e.ready  = (mq.size() < DEPTH);
    e.err    = m_err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic line(input bit fs_first);
    for (int i = 0; i < ACTIVE_W; i++) tick(1'b1, fs_first && (i == 0), 1'b0);
  endtask

  // Monitor: one expected entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rgb",       32'(rgb),    32'(e.rgb));
        chk("locked",    32'(locked), 32'(e.locked));
        chk("underflow", 32'(uf),     32'(e.uf));
        chk("sync_err",  32'(se),     32'(e.se));
        chk("err_cnt",   32'(errc),   32'(e.err));
        chk("ready",     32'(s_if.o_ready), 32'(e.ready));
        if (e.is_pix) $display("txn pixel rgb=%06h locked=%0d t=%0t", rgb, locked, $time);
      end
    end
  end

  initial begin
    rstn = 1'b0; act = 1'b0; fs = 1'b0;
    s_if.i_valid = 1'b0; s_if.i_data = '0; s_if.i_sof = 1'b0; s_if.i_eol = 1'b0;
    m_mode = HUNT; m_col = 0; m_err = 0; m_run = 0;

    // Reset state
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    idle(2);

    // Clean 2-line frame, pixels 1..16
    for (int i = 1; i <= 16; i++) add_pix(24'(i), i == 1, (i % 8) == 0);
    idle(20);
    line(1'b1); line(1'b0);
    idle(4);

    // Overfill with 20 pixels, then drain until underflow mid-line
    for (int i = 0; i < 20; i++) add_pix(24'h200 + 24'(i), i == 0, (i % 8) == 7);
    idle(25);
    line(1'b1); idle(2); line(1'b0); idle(2); line(1'b0);
    idle(3);

    // Short line (eol on 5th pixel), then junk, then a good frame
    for (int i = 0; i < 8; i++) add_pix(24'h300 + 24'(i), i == 0, i == 7);
    for (int i = 0; i < 8; i++) add_pix(24'h310 + 24'(i), 1'b0, i == 4);
    idle(20);
    line(1'b1); line(1'b0);
    for (int i = 0; i < 5; i++) add_pix(24'($urandom) | 24'h1, 1'b0, 1'($urandom));
    for (int i = 0; i < 16; i++) add_pix(24'h400 + 24'(i), i == 0, (i % 8) == 7);
    idle(30);
    line(1'b1); line(1'b0);
    idle(3);

    // Randomised frames with a throttled source and one injected bad eol
    vprob = 70;
    for (int f = 0; f < 6; f++) begin
      for (int p = 0; p < 16; p++) begin
        add_pix(24'($urandom), p == 0, ((p % 8) == 7) || (f == 3 && p == 10));
      end
    end
    for (int f = 0; f < 8; f++) begin
      idle(10 + int'($urandom_range(0, 6)));
      line(1'b1);
      idle(int'($urandom_range(1, 4)));
      line(1'b0);
    end
    vprob = 100;
    src.delete();

    // Reset clears the error count
    repeat (2) tick(1'b0, 1'b0, 1'b1);
    idle(2);

    // Reset mid-line with 10 entries buffered
    for (int i = 0; i < 13; i++) add_pix(24'h500 + 24'(i), i == 0, i == 7);
    idle(16);
    tick(1'b1, 1'b1, 1'b0); tick(1'b1, 1'b0, 1'b0); tick(1'b1, 1'b0, 1'b0);
    src.delete();
    tick(1'b1, 1'b0, 1'b1);
    #1;
    chk("rst_now_rgb",    32'(rgb),    32'(FILL));
    chk("rst_now_locked", 32'(locked), 32'd0);
    chk("rst_now_ready",  32'(s_if.o_ready), 32'd1);
    tick(1'b0, 1'b0, 1'b1);
    idle(3);

    // No stream: unlocked active lines (fill, or bars when enabled)
    line(1'b1); idle(3); line(1'b0); idle(2);

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdmi_stream_aligner.md
Name: hdmi_stream_aligner

Overview:
- Buffers a pixel stream (data/valid/ready with start-of-frame and end-of-line flags) in an internal FIFO.
- Releases pixels to the HDMI encoder only during active video, locked to the encoder's frame start.
- Checks stream framing against the configured line length; on any error or underflow it drops lock and resynchronises on the next start-of-frame.
- Sits between the video DMA stream and the hdmi core's rgb input, all in the pixel clock domain.

Parameters:
- PIX_W, 24, pixel width in bits; must be a multiple of 3 (R,G,B channels of PIX_W/3, R in MSBs).
- DEPTH, 1024, FIFO entries; power of two, >= 4.
- ACTIVE_W, 1280, active pixels per line expected from both the stream and the timing.
- FILL_COLOR, 0, PIX_W-bit value driven while not supplying stream pixels.

Ports:
- i_clk_pixel  in  1  pixel clock; all logic on its rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_data  in  PIX_W  stream pixel.
- i_valid  in  1  stream pixel valid.
- o_ready  out  1  stream ready; a transfer occurs when i_valid && o_ready.
- i_sof  in  1  first pixel of frame; qualified by the transfer.
- i_eol  in  1  last pixel of line; qualified by the transfer.
- i_active  in  1  encoder video data period; a pixel is consumed on every cycle it is high.
- i_frame_start  in  1  one-cycle pulse, coincident with the first active pixel of each frame.
- o_rgb  out  PIX_W  pixel to encoder.
- o_locked  out  1  high while in STREAM.
- o_underflow  out  1  one-cycle pulse on underflow.
- o_sync_err  out  1  one-cycle pulse on a framing error.
- o_err_cnt  out  16  saturating count of underflow plus framing errors.

Behaviour:
- Reset: FIFO empty, state RESYNC, o_rgb=FILL_COLOR, o_locked=0, pulses=0, o_err_cnt=0, column counter=0. Asynchronous assertion mid-frame discards all buffered data.
- FIFO: entries are {sof,eol,data}. o_ready = !full, combinational from the occupancy count. A push and a pop in the same cycle leave occupancy unchanged. Occupancy ranges 0..DEPTH.
- Output latency: o_rgb is registered and updates one cycle after the i_active cycle that consumes the pixel. When i_active=0, o_rgb holds FILL_COLOR.
- State RESYNC, o_locked=0:
  - Each cycle, if the head entry is not sof, pop it (discard).
  - If the head entry is sof, go to WAIT_FRAME without popping.
  - Active cycles output the fill value.
- State WAIT_FRAME:
  - Hold the head entry.
  - On i_frame_start && i_active: pop the head, o_rgb<=data, column=1, go to STREAM.
  - If the head is not sof (cannot occur) or the FIFO is empty at i_frame_start, treat as underflow.
- State STREAM, o_locked=1. On each i_active cycle:
  - FIFO empty: o_rgb<=fill, o_underflow=1, go to RESYNC.
  - Otherwise pop. Popped eol at column==ACTIVE_W-1: column<=0.
  - Popped eol at any other column, or non-eol at column==ACTIVE_W-1: o_sync_err=1, go to RESYNC. The popped data is still output.
  - Popped sof without i_frame_start, or i_frame_start with a non-sof head: o_sync_err=1, go to RESYNC. The offending entry is not popped if it is sof.
- Column counter width is clog2(ACTIVE_W).
- Simultaneous underflow and framing error count as one error: o_underflow has priority and o_sync_err stays low.
- o_err_cnt increments by 1 per error event and saturates at 16'hFFFF.
- Pushes continue in every state while not full.

Optional Feature:
- Macro: HDMI_ALIGN_BARS_EN.
- Defined: while o_locked=0, active cycles output colour bars instead of FILL_COLOR.
  - A local counter of consecutive i_active cycles is reset when i_active=0.
  - Counter < ACTIVE_W/3: blue (low channel all-ones).
  - Counter < 2*ACTIVE_W/3: green (middle channel all-ones).
  - Otherwise: red (high channel all-ones).
- Not defined: counter logic is absent and FILL_COLOR is output.

Test Plan (bench uses ACTIVE_W=8, DEPTH=16, PIX_W=24, FILL_COLOR=24'h101010):
- Reset, then push a 2-line frame (pixels 1..16, sof on 1, eol on 8 and 16) and pulse i_frame_start with i_active for 2x8 cycles -> o_rgb = 1..16 each one cycle delayed; o_locked=1 from the cycle after the first pixel; no pulses.
- Push 20 pixels with i_active=0 -> o_ready falls after 16 accepted; occupancy 16; the 17th pixel is held until a pop.
- Locked, stall the stream so the FIFO empties mid-line -> o_underflow pulses once, o_rgb=24'h101010, o_locked=0, o_err_cnt=1.
- Push a line with eol on pixel 5 -> o_sync_err pulses at the 5th active pixel, state RESYNC. Pushing junk pixels, then a sof frame -> junk discarded; relock at the next i_frame_start.
- Assert i_rstn=0 mid-line with 10 entries buffered -> o_rgb=FILL immediately; after release o_ready=1, o_err_cnt=0, FIFO empty.
- With HDMI_ALIGN_BARS_EN and no stream -> each 8-pixel active line outputs 0000FF x2, 00FF00 x3, FF0000 x3.
